// File: rtl/rdy_vld_skid_buf_if.sv
// rdy_vld_if: ready/valid channel carrying a payload of type vld_data_st.
// The producer uses the src modport and the consumer uses the dst modport.
interface rdy_vld_if #(
    parameter type vld_data_st = logic [1:0]
) ();
    logic       vld;
    logic       rdy;
    vld_data_st vld_data;

    modport src (output vld, output vld_data, input rdy);
    modport dst (input vld, input vld_data, output rdy);
endinterface

// File: rtl/rdy_vld_skid_buf.sv
// rdy_vld_skid_buf: two-entry skid buffer that registers a ready/valid channel
// in both directions. m_if.vld, m_if.vld_data and s_if.rdy all come straight
// from flops, so neither the forward nor the backward path is combinational.
// It sustains one beat per cycle and adds one cycle of forward latency.
//
// Optional checking: define RDY_VLD_SKID_BUF_ASSERT_EN to compile in the
// protocol/occupancy assertions. The macro has no effect on behaviour.
module rdy_vld_skid_buf #(
    parameter type vld_data_st = logic [1:0]
) (
    input  logic       clk,
    input  logic       rst_n,
    rdy_vld_if.dst     s_if,
    rdy_vld_if.src     m_if,
    output logic [1:0] occ
);

    // The encoding equals the occupancy, so occ is read straight off the state.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_e;

    state_e     state_q, state_d;
    logic       rdy_q;
    vld_data_st main_q, skid_q;
    logic       load_main, main_from_skid, load_skid;
    logic       in_xfer, out_xfer;

    assign in_xfer  = s_if.vld & rdy_q;
    assign out_xfer = (state_q != EMPTY) & m_if.rdy;

    // Next-state and register-load decode for the EMPTY/BUSY/FULL machine.
    always_comb begin
        // NOTE: every signal written here gets a default first so no path
        // through the case leaves it unassigned and infers a latch.
        state_d        = state_q;
        load_main      = 1'b0;
        main_from_skid = 1'b0;
        load_skid      = 1'b0;
        case (state_q)
            EMPTY: begin
                if (in_xfer) begin
                    load_main = 1'b1;
                    state_d   = BUSY;
                end
            end
            BUSY: begin
                if (in_xfer && !out_xfer) begin
                    load_skid = 1'b1;
                    state_d   = FULL;
                end else if (in_xfer && out_xfer) begin
                    load_main = 1'b1;
                end else if (out_xfer) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                // s_if.rdy is low here, so only the downstream side can move.
                if (out_xfer) begin
                    load_main      = 1'b1;
                    main_from_skid = 1'b1;
                    state_d        = BUSY;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // State register and registered upstream ready.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of block evaluation order.
        if (!rst_n) begin
            state_q <= EMPTY;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rdy_q   <= (state_d != FULL);
        end
    end

    // Payload registers: main feeds m_if.vld_data, skid catches the beat that
    // arrives in the cycle s_if.rdy is still high after downstream stalls.
    always_ff @(posedge clk) begin
        // NOTE: data registers are deliberately not reset; m_if.vld qualifies
        // them, and leaving them out of the reset tree keeps them cheap.
        if (load_main) main_q <= main_from_skid ? skid_q : s_if.vld_data;
        if (load_skid) skid_q <= s_if.vld_data;
    end

    assign m_if.vld      = (state_q != EMPTY);
    assign m_if.vld_data = main_q;
    assign s_if.rdy      = rdy_q;
    assign occ           = state_q;

`ifdef RDY_VLD_SKID_BUF_ASSERT_EN
    // Marks the end of the first cycle after reset, when s_if.rdy still
    // carries its reset value and lags the occupancy by design.
    logic post_rst_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) post_rst_q <= 1'b0;
        else        post_rst_q <= 1'b1;
    end

    a_s_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (s_if.vld && !s_if.rdy) |=> (s_if.vld && $stable(s_if.vld_data)));

    a_m_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (m_if.vld && !m_if.rdy) |=> (m_if.vld && $stable(m_if.vld_data)));

    a_occ_enc: assert property (@(posedge clk) disable iff (!rst_n)
        (occ <= 2'd2) && (occ == state_q));

    a_rdy_occ: assert property (@(posedge clk) disable iff (!rst_n)
        post_rst_q |-> (s_if.rdy == (occ != 2'd2)));

    a_no_x: assert property (@(posedge clk) disable iff (!rst_n)
        !$isunknown(m_if.vld) && !$isunknown(s_if.rdy));
`endif

endmodule

// File: tb/tb_rdy_vld_skid_buf.sv
// tb_rdy_vld_skid_buf: directed and random traffic through the skid buffer.
// A stimulus process pushes each accepted beat into a queue; a monitor pops
// and compares whenever a downstream transfer occurs. Inputs change at
// posedge+1, outputs are sampled on the falling edge.
module tb_rdy_vld_skid_buf;

    logic       clk;
    logic       rst_n;
    logic [1:0] occ;
    int         n_checks;
    int         n_errors;
    int         cyc;

    logic [1:0] exp_q[$];

    rdy_vld_if #(.vld_data_st(logic [1:0])) s_bus ();
    rdy_vld_if #(.vld_data_st(logic [1:0])) m_bus ();

    rdy_vld_skid_buf #(.vld_data_st(logic [1:0])) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .s_if  (s_bus),
        .m_if  (m_bus),
        .occ   (occ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Offer one beat upstream and hold it until accepted (bounded wait).
    task automatic send(input logic [1:0] d, output logic [1:0] occ_seen);
        bit done;
        done = 0;
        occ_seen = 2'd3;
        s_bus.vld      = 1'b1;
        s_bus.vld_data = d;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (s_bus.rdy) begin
                exp_q.push_back(d);
                occ_seen = occ;
                done = 1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) check("send_accept_timeout", 32'd0, 32'd1);
    endtask

    // Let everything flow out with downstream ready held high.
    task automatic drain();
        m_bus.rdy = 1'b1;
        s_bus.vld = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0 && !m_bus.vld) break;
        end
        check("drain_empty", {31'd0, (exp_q.size() == 0) && !m_bus.vld}, 32'd1);
    endtask

    // Monitor: scoreboard pop on each transfer, downstream hold rule, occ range.
    logic       prev_stall;
    logic [1:0] prev_data;
    initial begin
        prev_stall = 1'b0;
        prev_data  = 2'd0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("m_vld_held", {31'd0, m_bus.vld}, 32'd1);
                    check("m_data_held", {30'd0, m_bus.vld_data}, {30'd0, prev_data});
                end
                check("occ_range", {31'd0, occ <= 2'd2}, 32'd1);
                if (m_bus.vld && m_bus.rdy) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_beat", {30'd0, m_bus.vld_data}, 32'hffff_ffff);
                    end else begin
                        check("beat_data", {30'd0, m_bus.vld_data}, {30'd0, exp_q.pop_front()});
                    end
                end
                prev_stall = m_bus.vld && !m_bus.rdy;
                prev_data  = m_bus.vld_data;
            end
        end
    end

    // Watchdog: never let the run hang.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    logic [1:0] stream_v[8] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
    logic [1:0] post_v[4]   = '{2'd3, 2'd2, 2'd1, 2'd0};

    initial begin
        logic [1:0] os;
        int         c0;
        bit         acc;
        n_checks = 0;
        n_errors = 0;
        cyc      = 0;
        rst_n          = 1'b0;
        s_bus.vld      = 1'b0;
        s_bus.vld_data = 2'd0;
        m_bus.rdy      = 1'b1;

        // Reset state and release.
        @(negedge clk);
        #1;
        check("rst_m_vld", {31'd0, m_bus.vld}, 32'd0);
        check("rst_occ",   {30'd0, occ},       32'd0);
        check("rst_s_rdy", {31'd0, s_bus.rdy}, 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        #1 check("rel_s_rdy_before_edge", {31'd0, s_bus.rdy}, 32'd0);
        @(posedge clk);
        #1 check("rel_s_rdy_after_edge", {31'd0, s_bus.rdy}, 32'd1);
        check("rel_m_vld", {31'd0, m_bus.vld}, 32'd0);

        // Streaming: eight beats in eight cycles, one-cycle latency, occ=1.
        c0 = cyc;
        for (int i = 0; i < 8; i++) begin
            send(stream_v[i], os);
            if (i > 0) check("stream_occ", {30'd0, os}, 32'd1);
            check("stream_lat_vld",  {31'd0, m_bus.vld},      32'd1);
            check("stream_lat_data", {30'd0, m_bus.vld_data}, {30'd0, stream_v[i]});
            check("stream_occ_after", {30'd0, occ}, 32'd1);
        end
        check("stream_cycles", cyc - c0, 32'd8);
        drain();

        // Stall mid-burst: D2 accepted while downstream drops ready -> FULL.
        send(2'd1, os);
        m_bus.rdy = 1'b0;
        send(2'd2, os);
        check("stall_occ",    {30'd0, occ},            32'd2);
        check("stall_s_rdy",  {31'd0, s_bus.rdy},      32'd0);
        check("stall_m_data", {30'd0, m_bus.vld_data}, 32'd1);
        fork
            send(2'd3, os);
            begin
                repeat (3) @(posedge clk);
                #1;
                check("stall_hold_occ",  {30'd0, occ},            32'd2);
                check("stall_hold_data", {30'd0, m_bus.vld_data}, 32'd1);
                check("stall_hold_rdy",  {31'd0, s_bus.rdy},      32'd0);
                m_bus.rdy = 1'b1;
            end
        join
        drain();

        // Random traffic, upstream honours the hold rule while not ready.
        acc = 0;
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            acc = s_bus.vld && s_bus.rdy;
            if (acc) exp_q.push_back(s_bus.vld_data);
            @(posedge clk);
            #1;
            m_bus.rdy = 1'($urandom_range(0, 1));
            if (!s_bus.vld || acc) begin
                s_bus.vld      = 1'($urandom_range(0, 1));
                s_bus.vld_data = 2'($urandom_range(0, 3));
            end
        end
        drain();

        // Reset mid-operation from FULL.
        m_bus.rdy = 1'b0;
        send(2'd1, os);
        send(2'd2, os);
        s_bus.vld = 1'b0;
        check("pre_rst_occ", {30'd0, occ}, 32'd2);
        rst_n = 1'b0;
        #1;
        check("mid_rst_m_vld", {31'd0, m_bus.vld}, 32'd0);
        check("mid_rst_occ",   {30'd0, occ},       32'd0);
        check("mid_rst_s_rdy", {31'd0, s_bus.rdy}, 32'd0);
        exp_q.delete();
        m_bus.rdy = 1'b1;
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) send(post_v[i], os);
        drain();

        check("final_queue_empty", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/rdy_vld_skid_buf.md
# rdy_vld_skid_buf

- Two-entry skid buffer that registers a `rdy_vld_if` channel in both directions: forward (`vld`, `vld_data`) and backward (`rdy`).
- Sits between a producer's `src` modport and a consumer's `dst` modport. It breaks the combinational `rdy` path and the data/valid timing path without losing throughput.
- Sustains one transfer per cycle and adds one cycle of forward latency.

## Interface
Parameters:
- `vld_data_st`, default `logic[1:0]`: payload type carried on both sides; must match the connected `rdy_vld_if` instances.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset; deassertion must be synchronised to `clk` externally.
- `s_if` interface `rdy_vld_if.dst`, width `vld_data_st`: upstream (slave) side; the block drives `s_if.rdy`.
- `m_if` interface `rdy_vld_if.src`, width `vld_data_st`: downstream (master) side; the block drives `m_if.vld` and `m_if.vld_data`.
- `occ` output 2: number of entries held (0, 1 or 2).

## Operation
- Transfer definitions:
  - in = `s_if.vld & s_if.rdy`
  - out = `m_if.vld & m_if.rdy`
- Storage: main register (drives `m_if.vld_data`) and skid register. Data registers are not reset.
- State machine states: EMPTY (`occ`=0), BUSY (`occ`=1), FULL (`occ`=2). Transitions:
  - EMPTY: in → main ← `s_if.vld_data`, go to BUSY; otherwise stay.
  - BUSY: in & !out → skid ← `s_if.vld_data`, go to FULL.
  - BUSY: in & out → main ← `s_if.vld_data`, stay in BUSY.
  - BUSY: !in & out → go to EMPTY.
  - BUSY: neither → hold.
  - FULL: out → main ← skid, go to BUSY.
  - FULL: in is impossible because `s_if.rdy`=0.
  - FULL: !out → hold.
- Output decode:
  - `m_if.vld` = (state != EMPTY), driven directly from the state flops.
  - `s_if.rdy` is a dedicated flop; next value = (next state != FULL).
- No combinational path from `m_if.rdy` to `s_if.rdy`, or from `s_if.vld` to `m_if.vld`.
- Ordering is strict FIFO; no beat is dropped or duplicated.
- Skid register content is unobservable except through the FULL→BUSY move.

## Timing
- Reset (`rst_n`=0, asynchronous):
  - state = EMPTY, `occ`=0, `m_if.vld`=0.
  - `s_if.rdy`=0.
  - `m_if.vld_data` undefined; checkers must ignore it while `m_if.vld`=0.
- First rising edge after `rst_n` deasserts: `s_if.rdy` becomes 1. No transfer is accepted on that edge.
- Latency: a beat accepted at edge N appears on `m_if` at edge N (visible in cycle N+1) when the buffer was EMPTY.
- Throughput: with `m_if.rdy` held at 1, one beat per cycle indefinitely; occupancy stays at 1.
- Backpressure: `m_if.rdy` falling while BUSY and in occurs → FULL. `s_if.rdy` drops one cycle later, which is why the skid entry is needed.
- Release from FULL: out moves skid to main. `s_if.rdy` rises on the same edge; the new beat is accepted the following cycle.
- Simultaneous in & out in BUSY: main reloads and occupancy is unchanged.
- Reset mid-operation: held entries are discarded immediately and outputs return to their reset values asynchronously.
- The block relies on the upstream keeping `vld` and `vld_data` stable while `vld` & !`rdy`. It guarantees the same downstream.

## Configuration
- Macro: `RDY_VLD_SKID_BUF_ASSERT_EN`.
- Defined: concurrent SVA is compiled in, each disabled while `rst_n`=0:
  - (a) `s_if.vld` & !`s_if.rdy` ⇒ next cycle `s_if.vld` and `$stable(s_if.vld_data)`.
  - (b) the same rule on `m_if`.
  - (c) `occ` never exceeds 2 and equals the state encoding.
  - (d) `s_if.rdy` == (`occ` != 2) outside the first post-reset cycle.
  - (e) no X on `m_if.vld` or `s_if.rdy`.
- Undefined: no assertion code; RDY_VLD_SKID_BUF_ASSERT_EN changes only checking, never RTL behaviour or timing.

## Test plan
- Reset release: `rst_n` 0→1 with `m_if.rdy`=1 → `m_if.vld`=0, `occ`=0, `s_if.rdy`=0 in reset; `s_if.rdy`=1 one edge after release.
- Streaming: send D1..D8 (0,1,2,3,0,1,2,3) back-to-back with `m_if.rdy`=1 → identical sequence on `m_if`, each one cycle later, 8 beats in 8 cycles, `occ`=1 throughout.
- Stall mid-burst: send D1,D2,D3 and drop `m_if.rdy` the cycle D2 is accepted → `occ`=2, `s_if.rdy`=0, `m_if.vld_data`=D1 held. Raise `m_if.rdy` → D1,D2,D3 delivered in order with no loss.
- Random traffic: random `s_if.vld` and `m_if.rdy` at 50% each for 10k cycles against a scoreboard → in-order, lossless, `occ` within 0..2.
- Reset mid-operation: fill to FULL, then pulse `rst_n` low for 1 cycle → `m_if.vld`=0 and `occ`=0 immediately; the next stream is delivered intact.
- With RDY_VLD_SKID_BUF_ASSERT_EN defined, drop `s_if.vld` while `s_if.rdy`=0 → assertion (a) fires.
